// File: rtl/branch_predictor_bht.sv
// Direct-mapped 2-bit BHT with execute-stage resolution of the six RV32I conditional branches.
// Fetch reads the table combinationally; execute trains one entry per rising edge.
module branch_predictor_bht #(
  parameter int          XLEN       = 32,
  parameter int          INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  parameter int          CNT_W      = 16,
  parameter logic [6:0]  bOp        = 7'h63,
  parameter logic [6:0]  jalOp      = 7'h6F,
  parameter logic [6:0]  jalrOp     = 7'h67
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [XLEN-1:0]  fetchPC,
  input  logic [6:0]       fetchOpCode,
  output logic             predictTaken,
  input  logic             resolveValid,
  input  logic [XLEN-1:0]  resolvePC,
  input  logic [6:0]       opCode,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  operand1,
  input  logic [XLEN-1:0]  operand2,
  input  logic             resolvePredTaken,
  output logic             PCsrc,
  output logic             mispredict,
  output logic [CNT_W-1:0] branchCount,
  output logic [CNT_W-1:0] mispredictCount
);

  localparam int ENTRIES = 2 ** INDEX_BITS;

  logic [1:0]            r_bht [ENTRIES];
  logic [CNT_W-1:0]      r_branchCount;
  logic [CNT_W-1:0]      r_mispredictCount;

  logic [INDEX_BITS-1:0] w_fetchIdx;
  logic [INDEX_BITS-1:0] w_resolveIdx;
  logic                  w_isBranch;
  logic                  w_legalBranch;
  logic                  w_isJump;
  logic                  w_taken;
  logic                  w_mispredict;
  logic [1:0]            w_entry;

  assign w_fetchIdx   = fetchPC[INDEX_BITS+1:2];
  assign w_resolveIdx = resolvePC[INDEX_BITS+1:2];

  always_comb begin
    predictTaken = 1'b0;
    if (fetchOpCode == bOp)
      predictTaken = r_bht[w_fetchIdx][1];
    else if (fetchOpCode == jalOp)
      predictTaken = 1'b1;
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'd0:    w_taken = (operand1 == operand2);
      3'd1:    w_taken = (operand1 != operand2);
      3'd4:    w_taken = ($signed(operand1) <  $signed(operand2));
      3'd5:    w_taken = ($signed(operand1) >= $signed(operand2));
      3'd6:    w_taken = (operand1 <  operand2);
      3'd7:    w_taken = (operand1 >= operand2);
      default: w_taken = 1'b0;
    endcase
  end

  // funct3 2/3 under the branch opcode is illegal: no redirect, no training, no statistics.
  assign w_isBranch    = resolveValid && (opCode == bOp);
  assign w_legalBranch = w_isBranch && (funct3 != 3'd2) && (funct3 != 3'd3);
  assign w_isJump      = resolveValid && ((opCode == jalOp) || (opCode == jalrOp));
  assign w_mispredict  = w_legalBranch && (w_taken != resolvePredTaken);

  assign PCsrc           = w_isJump || (w_legalBranch && w_taken);
  assign mispredict      = w_mispredict;
  assign branchCount     = r_branchCount;
  assign mispredictCount = r_mispredictCount;

  assign w_entry = r_bht[w_resolveIdx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++)
        r_bht[i] <= INIT_STATE;
    end else if (w_legalBranch) begin
      if (w_taken && (w_entry != 2'b11))
        r_bht[w_resolveIdx] <= w_entry + 2'b01;
      else if (!w_taken && (w_entry != 2'b00))
        r_bht[w_resolveIdx] <= w_entry - 2'b01;
    end
  end

  // Statistics saturate at all-ones so a long run never wraps back to small values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_branchCount     <= '0;
      r_mispredictCount <= '0;
    end else if (w_legalBranch) begin
      if (r_branchCount != {CNT_W{1'b1}})
        r_branchCount <= r_branchCount + 1'b1;
      if (w_mispredict && (r_mispredictCount != {CNT_W{1'b1}}))
        r_mispredictCount <= r_mispredictCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: a scoreboard queue is filled from a
// reference model as stimulus is driven and drained as DUT outputs are sampled.
module tb_branch_predictor_bht;

  localparam logic [6:0] B_OP    = 7'h63;
  localparam logic [6:0] JAL_OP  = 7'h6F;
  localparam logic [6:0] JALR_OP = 7'h67;
  localparam logic [6:0] ALU_OP  = 7'h33;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetchPC = '0;
  logic [6:0]  fetchOpCode = '0;
  logic        resolveValid = 1'b0;
  logic [31:0] resolvePC = '0;
  logic [6:0]  opCode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        resolvePredTaken = 1'b0;

  logic        predictTaken, PCsrc, mispredict;
  logic [15:0] branchCount, mispredictCount;
  logic        satPredictTaken, satPCsrc, satMispredict;
  logic [3:0]  satBranchCount, satMispredictCount;

  always #5 clock = ~clock;

  branch_predictor_bht dut (
    .clock(clock), .reset(reset), .fetchPC(fetchPC), .fetchOpCode(fetchOpCode),
    .predictTaken(predictTaken), .resolveValid(resolveValid), .resolvePC(resolvePC),
    .opCode(opCode), .funct3(funct3), .operand1(operand1), .operand2(operand2),
    .resolvePredTaken(resolvePredTaken), .PCsrc(PCsrc), .mispredict(mispredict),
    .branchCount(branchCount), .mispredictCount(mispredictCount)
  );

  branch_predictor_bht #(.CNT_W(4)) dutSat (
    .clock(clock), .reset(reset), .fetchPC(fetchPC), .fetchOpCode(fetchOpCode),
    .predictTaken(satPredictTaken), .resolveValid(resolveValid), .resolvePC(resolvePC),
    .opCode(opCode), .funct3(funct3), .operand1(operand1), .operand2(operand2),
    .resolvePredTaken(resolvePredTaken), .PCsrc(satPCsrc), .mispredict(satMispredict),
    .branchCount(satBranchCount), .mispredictCount(satMispredictCount)
  );

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t        scoreQ[$];
  int          checks = 0;
  int          errors = 0;

  logic [1:0]  mBht [64];
  int          mBranch16 = 0, mMisp16 = 0, mBranch4 = 0, mMisp4 = 0;

  function automatic logic modelTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return !($signed(a) < $signed(b));
      3'd6:    return a < b;
      3'd7:    return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic modelPredict(input logic [31:0] pc, input logic [6:0] opc);
    if (opc == B_OP) return mBht[pc[7:2]][1];
    return opc == JAL_OP;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) mBht[i] = 2'b01;
    mBranch16 = 0; mMisp16 = 0; mBranch4 = 0; mMisp4 = 0;
  endtask

  task automatic pushExp(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag = tag;
    e.value = value;
    scoreQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (scoreQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=%0h required=<entry>", observed);
      return;
    end
    e = scoreQ.pop_front();
    assert (observed === e.value) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.value);
    end
  endtask

  task automatic checkCounters();
    pushExp("branchCount", mBranch16);      checkOutput({16'h0, branchCount});
    pushExp("mispredictCount", mMisp16);    checkOutput({16'h0, mispredictCount});
    pushExp("satBranchCount", mBranch4);    checkOutput({28'h0, satBranchCount});
    pushExp("satMispredictCount", mMisp4);  checkOutput({28'h0, satMispredictCount});
  endtask

  // One pipeline cycle: drive fetch and execute, check combinational outputs,
  // then clock the edge, update the model and check the statistics.
  task automatic applyStimulus(input logic [31:0] fpc, input logic [6:0] fopc,
                               input logic valid, input logic [31:0] rpc,
                               input logic [6:0] opc, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic rpred);
    logic legal, taken, jump, expPc, expMisp, expPred;
    @(negedge clock);
    fetchPC = fpc; fetchOpCode = fopc; resolveValid = valid; resolvePC = rpc;
    opCode = opc; funct3 = f3; operand1 = a; operand2 = b; resolvePredTaken = rpred;
    #1;
    legal   = valid && (opc == B_OP) && (f3 != 3'd2) && (f3 != 3'd3);
    taken   = modelTaken(f3, a, b);
    jump    = valid && ((opc == JAL_OP) || (opc == JALR_OP));
    expPc   = jump || (legal && taken);
    expMisp = legal && (taken != rpred);
    expPred = modelPredict(fpc, fopc);
    pushExp("predictTaken", expPred);  checkOutput({31'h0, predictTaken});
    pushExp("PCsrc", expPc);           checkOutput({31'h0, PCsrc});
    pushExp("mispredict", expMisp);    checkOutput({31'h0, mispredict});
    @(posedge clock);
    #1;
    if (legal) begin
      if (taken && mBht[rpc[7:2]] != 2'b11) mBht[rpc[7:2]] = mBht[rpc[7:2]] + 2'b01;
      if (!taken && mBht[rpc[7:2]] != 2'b00) mBht[rpc[7:2]] = mBht[rpc[7:2]] - 2'b01;
      if (mBranch16 != 65535) mBranch16++;
      if (mBranch4 != 15) mBranch4++;
      if (expMisp && mMisp16 != 65535) mMisp16++;
      if (expMisp && mMisp4 != 15) mMisp4++;
    end
    checkCounters();
    resolveValid = 1'b0;
  endtask

  task automatic fetchOnly(input logic [31:0] fpc, input logic [6:0] fopc);
    applyStimulus(fpc, fopc, 1'b0, 32'h0, ALU_OP, 3'd0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    modelReset();
    repeat (3) @(posedge clock);
    #1;
    checkCounters();
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 64; i++) fetchOnly(i << 2, B_OP);
    fetchOnly(32'h100, JAL_OP);
    fetchOnly(32'h100, JALR_OP);

    // BEQ 5/5 trains entry 0 through 01 -> 10 -> 11 -> 11.
    applyStimulus(32'h100, B_OP, 1'b1, 32'h100, B_OP, 3'd0, 32'd5, 32'd5, 1'b0);
    applyStimulus(32'h100, B_OP, 1'b1, 32'h100, B_OP, 3'd0, 32'd5, 32'd5, 1'b0);
    applyStimulus(32'h100, B_OP, 1'b1, 32'h100, B_OP, 3'd0, 32'd5, 32'd5, 1'b1);
    applyStimulus(32'h100, B_OP, 1'b1, 32'h100, B_OP, 3'd0, 32'd5, 32'd5, 1'b1);
    fetchOnly(32'h100, B_OP);
    fetchOnly(32'h103, B_OP);
    checks++;
    assert (branchCount === 16'd4 && mispredictCount === 16'd2) else begin
      errors++;
      $error("[TB] FAIL training_stats observed=%0d/%0d expected=4/2", branchCount, mispredictCount);
    end

    applyStimulus(32'h104, B_OP, 1'b1, 32'h104, B_OP, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0);
    applyStimulus(32'h108, B_OP, 1'b1, 32'h108, B_OP, 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b0);
    applyStimulus(32'h10C, B_OP, 1'b1, 32'h10C, B_OP, 3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
    applyStimulus(32'h110, B_OP, 1'b1, 32'h110, B_OP, 3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
    applyStimulus(32'h114, B_OP, 1'b1, 32'h114, B_OP, 3'd1, 32'd3, 32'd9, 1'b1);
    fetchOnly(32'h104, B_OP);
    fetchOnly(32'h108, B_OP);

    applyStimulus(32'h120, B_OP, 1'b1, 32'h120, JAL_OP, 3'd0, 32'd0, 32'd0, 1'b0);
    applyStimulus(32'h120, B_OP, 1'b1, 32'h120, JALR_OP, 3'd0, 32'd0, 32'd0, 1'b0);
    applyStimulus(32'h120, B_OP, 1'b1, 32'h120, B_OP, 3'd2, 32'd4, 32'd4, 1'b1);
    applyStimulus(32'h120, B_OP, 1'b1, 32'h120, B_OP, 3'd3, 32'd4, 32'd4, 1'b1);
    fetchOnly(32'h120, B_OP);

    for (int i = 0; i < 20; i++)
      applyStimulus(32'h140, ALU_OP, 1'b1, 32'h140, B_OP, 3'd0, 32'd7, 32'd7, 1'b0);
    checks++;
    assert (satBranchCount === 4'hF && satMispredictCount === 4'hF) else begin
      errors++;
      $error("[TB] FAIL saturation observed=%0d/%0d expected=15/15", satBranchCount, satMispredictCount);
    end

    // Reset dropped between edges must clear state without a clock edge.
    @(posedge clock);
    #3;
    fetchPC = 32'h100; fetchOpCode = B_OP;
    reset = 1'b0;
    #1;
    modelReset();
    checkCounters();
    pushExp("predictTaken_in_reset", 32'h0);
    checkOutput({31'h0, predictTaken});
    @(negedge clock);
    reset = 1'b1;

    applyStimulus(32'h200, B_OP, 1'b1, 32'h200, B_OP, 3'd0, 32'd1, 32'd1, 1'b0);
    fetchOnly(32'h200, B_OP);

    if (scoreQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d required=0", scoreQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
